io_pins_capture: RTL and testbench

Input-side companion to the bidirectional pin bank: samples the 128 `io_pins` lines while a port is released (tri-stated), synchronises and debounces them per bit, and holds a filtered value per 8-bit port. Per-port sticky change flags, an interrupt, and a single-cycle read handshake let the host fetch a port value and acknowledge its change. The block sits between the pin bank and the host register interface, alongside the pin output registers.

---
 rtl/io_pins_capture.sv | 122 ++++++++++++
 tb/tb_io_pins_capture.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_pins_capture.sv
// Pin input capture: per-bit 2-flop synchroniser and debounce, per-port sticky
// change flags with interrupt, and a one-cycle registered read port.
module io_pins_capture #(
  parameter int NPORTS = 16,
  parameter int DEB    = 4,
  parameter int PW     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [8*NPORTS-1:0] pins_in,
  input  logic [NPORTS-1:0]   port_dir,
  input  logic                rd_req,
  input  logic [PW-1:0]       rd_port,
  output logic                rd_valid,
  output logic [7:0]          rd_data,
  output logic                rd_changed,
  output logic [NPORTS-1:0]   changed,
  output logic                irq
);

  localparam int NB = 8 * NPORTS;
  localparam int CW = $clog2(DEB + 1);
  localparam logic [CW-1:0] DEB_C = CW'(DEB);

  logic [NB-1:0]     stable;
  logic [NB-1:0]     upd;
  logic [NPORTS-1:0] hit;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_bit
      logic          s1_reg, s2_reg, cand_reg, stable_reg;
      logic [CW-1:0] cnt_reg;
      logic          upd_now;

      assign upd_now = (cnt_reg == DEB_C) && (stable_reg != cand_reg);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_reg     <= 1'b0;
          s2_reg     <= 1'b0;
          cand_reg   <= 1'b0;
          cnt_reg    <= '0;
          stable_reg <= 1'b0;
        end else begin
          s1_reg <= pins_in[gi];
          s2_reg <= s1_reg;
          if (s2_reg != cand_reg) begin
            cand_reg <= s2_reg;
            cnt_reg  <= CW'(1);
          end else if (cnt_reg < DEB_C) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
          if (upd_now)
            stable_reg <= cand_reg;
        end
      end

      assign stable[gi] = stable_reg;
      assign upd[gi]    = upd_now;
    end

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
      logic changed_reg;

      assign hit[gi] = rd_req && (32'(rd_port) == gi);

      // A new stable update outranks a read-clear landing on the same edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          changed_reg <= 1'b0;
        else if (!port_dir[gi])
          changed_reg <= 1'b0;
        else if (|upd[8*gi +: 8])
          changed_reg <= 1'b1;
        else if (hit[gi])
          changed_reg <= 1'b0;
      end

      assign changed[gi] = changed_reg;
    end
  endgenerate

  logic [7:0] rd_data_next;
  logic       rd_changed_next;

  // Out-of-range indices match no port and fall through to zero.
  always_comb begin
    rd_data_next    = '0;
    rd_changed_next = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (hit[i]) begin
        rd_data_next    = stable[8*i +: 8];
        rd_changed_next = changed[i];
      end
    end
  end

  logic       rd_valid_reg, rd_changed_reg, irq_reg;
  logic [7:0] rd_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_reg   <= 1'b0;
      rd_data_reg    <= '0;
      rd_changed_reg <= 1'b0;
      irq_reg        <= 1'b0;
    end else begin
      rd_valid_reg <= rd_req;
      irq_reg      <= |changed;
      if (rd_req) begin
        rd_data_reg    <= rd_data_next;
        rd_changed_reg <= rd_changed_next;
      end
    end
  end

  assign rd_valid   = rd_valid_reg;
  assign rd_data    = rd_data_reg;
  assign rd_changed = rd_changed_reg;
  assign irq        = irq_reg;

endmodule

// File: tb/tb_io_pins_capture.sv
// Bench for io_pins_capture: directed plan steps plus randomized pin/read traffic,
// all checked against a sample-history reference model.
module tb_io_pins_capture;

  localparam int NP  = 8;
  localparam int DEB = 4;
  localparam int NB  = 8 * NP;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] pins_in;
  logic [NP-1:0] port_dir;
  logic          rd_req;
  logic [3:0]    rd_port;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic          rd_changed;
  logic [NP-1:0] changed;
  logic          irq;

  int checks   = 0;
  int failures = 0;

  io_pins_capture #(.NPORTS(NP), .DEB(DEB), .PW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pins_in    (pins_in),
    .port_dir   (port_dir),
    .rd_req     (rd_req),
    .rd_port    (rd_port),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_changed (rd_changed),
    .changed    (changed),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Reference: a bit settles to the pin level sampled 3 edges ago once the
  // last DEB samples of that bit agree; pre-reset history counts as zero.
  logic [NB-1:0] hist[$];
  logic [NB-1:0] m_stable, m_eq, m_upd;
  logic [NP-1:0] m_changed, m_nch;
  logic          m_irq, m_rd_valid, m_rd_changed;
  logic [7:0]    m_rd_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist = {};
      for (int j = 0; j < DEB + 2; j++) hist.push_back('0);
      m_stable = '0; m_changed = '0; m_irq = 0;
      m_rd_valid = 0; m_rd_data = '0; m_rd_changed = 0;
    end else begin
      hist.push_back(pins_in);
      if (hist.size() > DEB + 3) void'(hist.pop_front());
      m_eq = '1;
      for (int j = 4; j < DEB + 3; j++)
        m_eq &= ~(hist[hist.size()-1-j] ^ hist[hist.size()-4]);
      m_upd = m_eq & (hist[hist.size()-4] ^ m_stable);
      for (int i = 0; i < NP; i++) begin
        if (!port_dir[i])                        m_nch[i] = 1'b0;
        else if (|m_upd[8*i +: 8])               m_nch[i] = 1'b1;
        else if (rd_req && int'(rd_port) == i)   m_nch[i] = 1'b0;
        else                                     m_nch[i] = m_changed[i];
      end
      m_irq = |m_changed;
      m_rd_valid = rd_req;
      if (rd_req) begin
        if (int'(rd_port) < NP) begin
          m_rd_data    = m_stable[int'(rd_port)*8 +: 8];
          m_rd_changed = m_changed[int'(rd_port)];
        end else begin
          m_rd_data = '0; m_rd_changed = 1'b0;
        end
      end
      m_stable  = m_stable ^ m_upd;
      m_changed = m_nch;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check("mdl_changed", changed, m_changed);
    check("mdl_irq", irq, m_irq);
    check("mdl_rd_valid", rd_valid, m_rd_valid);
    check("mdl_rd_data", rd_data, m_rd_data);
    check("mdl_rd_changed", rd_changed, m_rd_changed);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic read_port(input int p);
    rd_req = 1'b1; rd_port = 4'(p);
    step();
    rd_req = 1'b0;
  endtask

  task automatic clear_all();
    for (int p = 0; p < NP; p++) read_port(p);
    step();
  endtask

  initial begin
    rst_n = 1'b0; pins_in = '1; port_dir = '1; rd_req = 1'b0; rd_port = '0;
    @(negedge clk); @(negedge clk);
    check("rst_outputs", {changed, irq, rd_valid, rd_data, rd_changed}, '0);

    // Reset release with all pins high
    rst_n = 1'b1;
    steps(6);
    check("rel_changed_e6", changed, 8'h00);
    step();
    check("rel_changed_e7", changed, 8'hFF);
    check("rel_irq_e7", irq, 1'b0);
    step();
    check("rel_irq_e8", irq, 1'b1);
    read_port(3);
    check("rel_rd_valid", rd_valid, 1'b1);
    check("rel_rd_data", rd_data, 8'hFF);
    check("rel_rd_changed", rd_changed, 1'b1);

    // Glitch rejection on port 0 bit 0
    pins_in = '0;
    steps(10);
    clear_all();
    pins_in[0] = 1'b1;
    steps(3);
    pins_in[0] = 1'b0;
    steps(12);
    check("glitch3_changed0", changed[0], 1'b0);
    read_port(0);
    check("glitch3_data", rd_data, 8'h00);
    pins_in[0] = 1'b1;
    steps(4);
    pins_in[0] = 1'b0;
    steps(3);
    check("glitch4_changed0", changed[0], 1'b1);
    read_port(0);
    check("glitch4_data", rd_data, 8'h01);
    steps(10);
    clear_all();

    // Read handshake on port 5
    pins_in[47:40] = 8'hA5;
    steps(10);
    check("hs_flag_before", changed[5], 1'b1);
    rd_req = 1'b1; rd_port = 4'd5;
    step();
    check("hs_rd_valid", rd_valid, 1'b1);
    check("hs_rd_data", rd_data, 8'hA5);
    check("hs_rd_changed", rd_changed, 1'b1);
    check("hs_flag_after", changed[5], 1'b0);
    step();
    check("hs_reread_changed", rd_changed, 1'b0);
    rd_req = 1'b0;
    step();
    check("hs_valid_drop", rd_valid, 1'b0);
    check("hs_data_hold", rd_data, 8'hA5);

    // Read collides with stable update on port 2
    clear_all();
    pins_in[23:16] = 8'h5A;
    steps(6);
    check("col_flag_before", changed[2], 1'b0);
    read_port(2);
    check("col_rd_changed", rd_changed, 1'b0);
    check("col_rd_data_old", rd_data, 8'h00);
    check("col_flag_after", changed[2], 1'b1);

    // Direction masking on port 7
    port_dir[7] = 1'b0;
    pins_in[63:56] = 8'h3C;
    steps(10);
    check("dir_flag7", changed[7], 1'b0);
    read_port(7);
    check("dir_rd_data", rd_data, 8'h3C);
    port_dir = '1;
    step();

    // Out-of-range read leaves flags alone
    read_port(15);
    check("oor_rd_valid", rd_valid, 1'b1);
    check("oor_rd_data", rd_data, 8'h00);
    check("oor_rd_changed", rd_changed, 1'b0);
    check("oor_flags", changed, 8'h04);

    // Asynchronous reset in the middle of a debounce
    read_port(7);
    pins_in[7:0] = 8'hFF;
    steps(3);
    check("pre_rst_irq", irq, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {changed, irq, rd_valid, rd_data, rd_changed}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        int p;
        p = $urandom_range(0, NP - 1);
        pins_in[8*p +: 8] = pins_in[8*p +: 8] ^ 8'($urandom);
      end
      if ($urandom_range(0, 63) == 0)
        port_dir[$urandom_range(0, NP - 1)] ^= 1'b1;
      rd_req  = ($urandom_range(0, 2) == 0);
      rd_port = 4'($urandom_range(0, 15));
      step();
    end
    rd_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
